tree_walk_ctrl: RTL and testbench

- Sequences the walk of the message-hierarchy tree ROM while a decoder streams field symbols (FIELD, OPEN, CLOSE).
- Holds the tree node pointer: current node, level and path.
- For each symbol it scans the candidate child slots of the current level, resolves the received field identifier to a unique node id, and advances or rewinds the pointer.
- Sits between the field decoder and the per-node data consumers. It is the only master of the tree ROM read port.

---
 rtl/tree_walk_ctrl_if.sv | 40 ++++
 rtl/tree_walk_ctrl.sv | 174 +++++++++++++++++
 tb/tb_tree_walk_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tree_walk_ctrl_if.sv
// rtl/tree_walk_ctrl_if.sv - symbol, tree ROM, result and pointer channels of the tree walk controller
interface tree_walk_ctrl_if #(
  parameter int MAX_NODES_PER_LEVEL = 8,
  parameter int NUM_MSG_HIERARCHY   = 4,
  parameter int ID_W                = 16,
  parameter int LVL_W               = $clog2(NUM_MSG_HIERARCHY + 1),
  parameter int IDX_W               = $clog2(MAX_NODES_PER_LEVEL)
);
  logic                          sym_valid;
  logic                          sym_ready;
  logic [1:0]                    sym_kind;
  logic [ID_W-1:0]               sym_field_id;
  logic                          rom_rd_en;
  logic [LVL_W-1:0]              rom_level;
  logic [IDX_W-1:0]              rom_idx;
  logic [ID_W-1:0]               rom_node_id;
  logic [ID_W-1:0]               rom_parent_id;
  logic [ID_W-1:0]               rom_field_id;
  logic                          res_valid;
  logic                          res_ready;
  logic [ID_W-1:0]               res_node_id;
  logic [LVL_W-1:0]              res_level;
  logic                          res_err;
  logic [1:0]                    res_err_code;
  logic [ID_W-1:0]               cur_node_id;
  logic [LVL_W-1:0]              cur_level;
  logic [NUM_MSG_HIERARCHY*ID_W-1:0] cur_path;

  modport slave (
    input  sym_valid, sym_kind, sym_field_id, rom_node_id, rom_parent_id, rom_field_id, res_ready,
    output sym_ready, rom_rd_en, rom_level, rom_idx, res_valid, res_node_id, res_level,
           res_err, res_err_code, cur_node_id, cur_level, cur_path
  );

  modport master (
    output sym_valid, sym_kind, sym_field_id, rom_node_id, rom_parent_id, rom_field_id, res_ready,
    input  sym_ready, rom_rd_en, rom_level, rom_idx, res_valid, res_node_id, res_level,
           res_err, res_err_code, cur_node_id, cur_level, cur_path
  );
endinterface

// File: rtl/tree_walk_ctrl.sv
// rtl/tree_walk_ctrl.sv - walks the message-hierarchy tree ROM for streamed FIELD/OPEN/CLOSE symbols
module tree_walk_ctrl #(
  parameter int MAX_NODES_PER_LEVEL = 8,
  parameter int NUM_MSG_HIERARCHY   = 4,
  parameter int ID_W                = 16,
  parameter int LVL_W               = $clog2(NUM_MSG_HIERARCHY + 1),
  parameter int IDX_W               = $clog2(MAX_NODES_PER_LEVEL)
) (
  input  logic             clk,
  input  logic             rst_n,
  tree_walk_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam logic [1:0]       K_FIELD   = 2'd0;
  localparam logic [1:0]       K_OPEN    = 2'd1;
  localparam logic [1:0]       K_CLOSE   = 2'd2;
  localparam logic [1:0]       E_NOMATCH = 2'd1;
  localparam logic [1:0]       E_DEPTH   = 2'd2;
  localparam logic [1:0]       E_UNDER   = 2'd3;
  localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(NUM_MSG_HIERARCHY);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MAX_NODES_PER_LEVEL - 1);

  state_t           state;
  logic             sym_ready;
  logic             rom_rd_en;
  logic             rd_d;
  logic [LVL_W-1:0] rom_level;
  logic [IDX_W-1:0] rom_idx;
  logic [IDX_W-1:0] chk_idx;
  logic [1:0]       kind;
  logic [ID_W-1:0]  field_id;
  logic             res_valid;
  logic [ID_W-1:0]  res_node_id;
  logic [LVL_W-1:0] res_level;
  logic             res_err;
  logic [1:0]       res_err_code;
  logic [ID_W-1:0]  cur_node_id;
  logic [LVL_W-1:0] cur_level;
  logic [ID_W-1:0]  path [NUM_MSG_HIERARCHY];
  logic [ID_W-1:0]  close_parent;
  logic             slot_empty;
  logic             slot_hit;

  assign slot_empty = (bus.rom_node_id == '0);
  assign slot_hit   = !slot_empty && (bus.rom_parent_id == cur_node_id) &&
                      (bus.rom_field_id == field_id);

  // Node that becomes current after a CLOSE: the entry two below the current level.
  always_comb begin
    close_parent = '0;
    for (int i = 0; i < NUM_MSG_HIERARCHY; i++)
      if (LVL_W'(i + 2) == cur_level) close_parent = path[i];
  end

  always_comb begin
    bus.cur_path = '0;
    for (int i = 0; i < NUM_MSG_HIERARCHY; i++)
      bus.cur_path[i*ID_W +: ID_W] = path[i];
  end

  assign bus.sym_ready    = sym_ready;
  assign bus.rom_rd_en    = rom_rd_en;
  assign bus.rom_level    = rom_level;
  assign bus.rom_idx      = rom_idx;
  assign bus.res_valid    = res_valid;
  assign bus.res_node_id  = res_node_id;
  assign bus.res_level    = res_level;
  assign bus.res_err      = res_err;
  assign bus.res_err_code = res_err_code;
  assign bus.cur_node_id  = cur_node_id;
  assign bus.cur_level    = cur_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sym_ready    <= 1'b0;
      rom_rd_en    <= 1'b0;
      rd_d         <= 1'b0;
      rom_level    <= '0;
      rom_idx      <= '0;
      chk_idx      <= '0;
      kind         <= K_FIELD;
      field_id     <= '0;
      res_valid    <= 1'b0;
      res_node_id  <= '0;
      res_level    <= '0;
      res_err      <= 1'b0;
      res_err_code <= '0;
      cur_node_id  <= '0;
      cur_level    <= '0;
      for (int i = 0; i < NUM_MSG_HIERARCHY; i++) path[i] <= '0;
    end else begin
      // Data on the ROM outputs belongs to the read strobed one edge earlier.
      rd_d    <= rom_rd_en;
      chk_idx <= rom_idx;
      case (state)
        IDLE: begin
          sym_ready <= 1'b1;
          if (bus.sym_valid && sym_ready) begin
            sym_ready    <= 1'b0;
            kind         <= bus.sym_kind;
            field_id     <= bus.sym_field_id;
            res_node_id  <= '0;
            res_level    <= cur_level;
            res_err      <= 1'b0;
            res_err_code <= '0;
            if (bus.sym_kind == K_FIELD || (bus.sym_kind == K_OPEN && cur_level < LVL_MAX)) begin
              state     <= SCAN;
              rom_rd_en <= 1'b1;
              rom_level <= cur_level;
              rom_idx   <= '0;
            end else begin
              state     <= RESP;
              res_valid <= 1'b1;
              if (bus.sym_kind == K_OPEN) begin
                res_err      <= 1'b1;
                res_err_code <= E_DEPTH;
              end else if (bus.sym_kind == K_CLOSE && cur_level != '0) begin
                res_node_id <= cur_node_id;
                res_level   <= cur_level - LVL_W'(1);
                cur_level   <= cur_level - LVL_W'(1);
                cur_node_id <= close_parent;
                for (int i = 0; i < NUM_MSG_HIERARCHY; i++)
                  if (LVL_W'(i + 1) == cur_level) path[i] <= '0;
              end else begin
                res_err      <= 1'b1;
                res_err_code <= E_UNDER;
              end
            end
          end
        end
        SCAN: begin
          if (rom_rd_en) begin
            if (rom_idx == IDX_LAST) begin
              rom_rd_en <= 1'b0;
              rom_level <= '0;
              rom_idx   <= '0;
            end else begin
              rom_idx <= rom_idx + IDX_W'(1);
            end
          end
          if (rd_d && (slot_hit || slot_empty || chk_idx == IDX_LAST)) begin
            state     <= RESP;
            res_valid <= 1'b1;
            rom_rd_en <= 1'b0;
            rom_level <= '0;
            rom_idx   <= '0;
            if (slot_hit) begin
              res_node_id <= bus.rom_node_id;
              if (kind == K_OPEN) begin
                cur_node_id <= bus.rom_node_id;
                cur_level   <= cur_level + LVL_W'(1);
                for (int i = 0; i < NUM_MSG_HIERARCHY; i++)
                  if (LVL_W'(i) == cur_level) path[i] <= bus.rom_node_id;
              end
            end else begin
              res_err      <= 1'b1;
              res_err_code <= E_NOMATCH;
            end
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            sym_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tree_walk_ctrl.sv
// tb/tb_tree_walk_ctrl.sv - directed and randomized checks of tree_walk_ctrl against a path-stack model
module tb_tree_walk_ctrl;
  localparam int MAXN = 8;
  localparam int NLVL = 4;

  logic clk;
  logic rst_n;
  tree_walk_ctrl_if bus ();

  tree_walk_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] rn [NLVL][MAXN];
  logic [15:0] rp [NLVL][MAXN];
  logic [15:0] rf [NLVL][MAXN];
  logic [15:0] mpath [$];
  int n_assert = 0;
  int n_fail   = 0;
  int rd_total = 0;

  always @(posedge clk) begin
    if (bus.rom_rd_en === 1'b1) begin
      rd_total++;
      bus.rom_node_id   <= rn[bus.rom_level[1:0]][bus.rom_idx];
      bus.rom_parent_id <= rp[bus.rom_level[1:0]][bus.rom_idx];
      bus.rom_field_id  <= rf[bus.rom_level[1:0]][bus.rom_idx];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_path();
    logic [63:0] p = '0;
    for (int i = 0; i < mpath.size(); i++) p[i*16 +: 16] = mpath[i];
    return p;
  endfunction

  task automatic clear_rom();
    for (int l = 0; l < NLVL; l++)
      for (int s = 0; s < MAXN; s++) begin
        rn[l][s] = '0; rp[l][s] = '0; rf[l][s] = '0;
      end
  endtask

  task automatic set_slot(input int l, input int s, input int n, input int p, input int f);
    rn[l][s] = 16'(n); rp[l][s] = 16'(p); rf[l][s] = 16'(f);
  endtask

  task automatic rand_rom(input bit full0);
    int cnt, prev;
    prev = 0;
    for (int l = 0; l < NLVL; l++) begin
      cnt = (l == 0) ? (full0 ? MAXN : int'($urandom_range(2, MAXN))) : int'($urandom_range(0, MAXN));
      for (int s = 0; s < MAXN; s++) begin
        rf[l][s] = 16'($urandom_range(1, 4));
        if (s < cnt) begin
          rn[l][s] = 16'(l * 8 + s + 1);
          if (l == 0) rp[l][s] = ($urandom_range(0, 5) == 0) ? 16'h0099 : 16'h0000;
          else if (prev > 0) rp[l][s] = rn[l-1][$urandom_range(0, prev - 1)];
          else rp[l][s] = 16'h0055;
        end else begin
          rn[l][s] = '0;
          rp[l][s] = (l == 0) ? 16'h0000 : 16'(l * 8 - 7);
        end
      end
      prev = cnt;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.sym_valid = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mpath.delete();
  endtask

  task automatic do_sym(input logic [1:0] kind, input logic [15:0] fid, input int hold, input string tag);
    logic [15:0] e_node, parent;
    logic [2:0]  e_lvl;
    logic [1:0]  e_code;
    int lvl, e_lat, e_k, waited, lat, rdn;
    bit e_scan;
    logic [22:0] snap;

    lvl = mpath.size();
    parent = (lvl == 0) ? 16'h0 : mpath[lvl-1];
    e_node = '0; e_lvl = 3'(lvl); e_code = 2'd0; e_scan = 0; e_lat = 1; e_k = 0;
    if (kind == 2'd3) e_code = 2'd3;
    else if (kind == 2'd2) begin
      if (lvl == 0) e_code = 2'd3;
      else begin e_node = mpath[lvl-1]; e_lvl = 3'(lvl - 1); end
    end else if (kind == 2'd1 && lvl == NLVL) e_code = 2'd2;
    else begin
      e_scan = 1; e_code = 2'd1; e_k = MAXN - 1;
      for (int s = 0; s < MAXN; s++) begin
        if (rn[lvl][s] == 16'h0) begin e_k = s; break; end
        if (rp[lvl][s] == parent && rf[lvl][s] == fid) begin
          e_k = s; e_code = 2'd0; e_node = rn[lvl][s]; break;
        end
      end
      e_lat = e_k + 3;
    end

    waited = 0;
    while (bus.sym_ready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    check({tag, ":sym_ready"}, 64'(bus.sym_ready), 64'd1);
    if (bus.sym_ready !== 1'b1) return;
    bus.sym_valid = 1'b1; bus.sym_kind = kind; bus.sym_field_id = fid;
    rdn = rd_total;
    @(posedge clk);
    @(negedge clk);
    bus.sym_valid = 1'b0; bus.sym_kind = 2'($urandom); bus.sym_field_id = 16'($urandom);
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    rdn = rd_total - rdn;
    check({tag, ":latency"}, 64'(lat), 64'(e_lat));
    check({tag, ":res_node"}, 64'(bus.res_node_id), 64'(e_node));
    check({tag, ":res_level"}, 64'(bus.res_level), 64'(e_lvl));
    check({tag, ":res_err"}, {62'd0, bus.res_err, 1'b0} | 64'(bus.res_err_code),
          {62'd0, (e_code != 2'd0), 1'b0} | 64'(e_code));
    if (e_scan) check({tag, ":rom_reads_in_window"}, 64'(rdn >= e_k + 1 && rdn <= e_k + 2), 64'd1);
    else        check({tag, ":rom_reads"}, 64'(rdn), 64'd0);

    snap = {bus.res_valid, bus.res_node_id, bus.res_level, bus.res_err, bus.res_err_code};
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check({tag, ":hold"}, {40'd0, bus.sym_ready,
            bus.res_valid, bus.res_node_id, bus.res_level, bus.res_err, bus.res_err_code},
            {40'd0, 1'b0, snap});
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({tag, ":after_consume"}, {62'd0, bus.res_valid, bus.sym_ready}, 64'd1);

    if (kind == 2'd1 && e_code == 2'd0) mpath.push_back(e_node);
    if (kind == 2'd2 && e_code == 2'd0) void'(mpath.pop_back());
    check({tag, ":cur_level"}, 64'(bus.cur_level), 64'(mpath.size()));
    check({tag, ":cur_node"}, 64'(bus.cur_node_id), 64'((mpath.size() == 0) ? 16'h0 : mpath[mpath.size()-1]));
    check({tag, ":cur_path"}, bus.cur_path, model_path());
  endtask

  initial begin
    int rd_snap;
    rst_n = 1'b0;
    bus.sym_valid = 1'b0; bus.sym_kind = 2'd0; bus.sym_field_id = '0; bus.res_ready = 1'b0;
    clear_rom();
    set_slot(0, 0, 1, 0, 10); set_slot(0, 1, 2, 0, 20);
    set_slot(1, 0, 3, 1, 5);  set_slot(1, 1, 4, 2, 5);
    set_slot(2, 0, 5, 3, 7);  set_slot(3, 0, 6, 5, 8);

    repeat (3) @(negedge clk);
    check("reset_outs", {26'd0, bus.sym_ready, bus.rom_rd_en, bus.rom_level, bus.rom_idx,
          bus.res_valid, bus.res_node_id, bus.res_level, bus.res_err, bus.res_err_code}, 64'd0);
    check("reset_cur", {45'd0, bus.cur_level, bus.cur_node_id}, 64'd0);
    check("reset_path", bus.cur_path, 64'd0);
    rst_n = 1'b1;
    #1 check("ready_low_before_edge", 64'(bus.sym_ready), 64'd0);
    @(negedge clk);
    check("ready_after_first_edge", 64'(bus.sym_ready), 64'd1);

    do_sym(2'd0, 16'd20, 0, "s1_field20");
    do_sym(2'd1, 16'd10, 0, "s2_open10");
    do_sym(2'd0, 16'd5, 0, "s2_field5");
    do_sym(2'd2, 16'd0, 0, "s2_close");
    do_sym(2'd0, 16'd99, 0, "s3_field99");
    do_sym(2'd2, 16'd0, 0, "s4_close_root");
    do_sym(2'd3, 16'd10, 0, "s4_bad_kind");
    do_sym(2'd1, 16'd10, 0, "s4_open10");
    do_sym(2'd1, 16'd5, 0, "s4_open5");
    do_sym(2'd2, 16'd0, 0, "s4_close");
    check("s4_path1_cleared", 64'(bus.cur_path[31:16]), 64'd0);
    do_sym(2'd1, 16'd5, 0, "s5_open5");
    do_sym(2'd1, 16'd7, 0, "s5_open7");
    do_sym(2'd1, 16'd8, 0, "s5_open8");
    check("s5_level4", 64'(bus.cur_level), 64'd4);
    do_sym(2'd1, 16'd1, 0, "s5_open_overflow");
    do_sym(2'd0, 16'd8, 5, "s5_hold5");
    repeat (4) do_sym(2'd2, 16'd0, 0, "s5_unwind");

    // Reset in the middle of a scan.
    @(negedge clk);
    bus.sym_valid = 1'b1; bus.sym_kind = 2'd0; bus.sym_field_id = 16'd10;
    @(posedge clk);
    @(negedge clk);
    bus.sym_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("s6_async_outs", {26'd0, bus.sym_ready, bus.rom_rd_en, bus.rom_level, bus.rom_idx,
          bus.res_valid, bus.res_node_id, bus.res_level, bus.res_err, bus.res_err_code}, 64'd0);
    check("s6_async_cur", {45'd0, bus.cur_level, bus.cur_node_id}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mpath.delete();
    rd_snap = rd_total;
    @(negedge clk);
    check("s6_ready_after_release", {62'd0, bus.res_valid, bus.sym_ready}, 64'd1);
    repeat (3) @(negedge clk);
    check("s6_no_result_no_read", {62'd0, bus.res_valid, (rd_total != rd_snap)}, 64'd0);
    do_sym(2'd0, 16'd10, 0, "s6_field10");

    for (int round = 0; round < 3; round++) begin
      rand_rom(round == 0);
      do_reset();
      for (int n = 0; n < 40; n++) begin
        int r;
        logic [1:0] k;
        r = $urandom_range(0, 9);
        k = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        do_sym(k, 16'($urandom_range(1, 5)), $urandom_range(0, 2), "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
